// File: rtl/axil_reg_bank_pkg.sv
// axil_reg_bank_pkg: response codes and register modes shared by the register bank.
package axil_reg_bank_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {RW, RO, W1C} reg_mode_e;
endpackage

// File: rtl/axil_reg_bank_if.sv
// axil_reg_bank_if: AXI4-Lite bus bundle between the processing system and the register bank.
interface axil_reg_bank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axil_reg_bank_cell.sv
// axil_reg_cell: one bank register with byte-strobe merge, W1C/hardware-set logic and write pulse.
module axil_reg_cell
    import axil_reg_bank_pkg::*;
#(
    parameter int        DW   = 32,
    parameter reg_mode_e MODE = RW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic [DW-1:0]   hw_in,
    input  logic [DW-1:0]   hw_set,
    output logic [DW-1:0]   q,
    output logic            wr_pulse
);
    logic [DW-1:0] r, m, nxt;

    always_comb begin
        m = '0;
        for (int b = 0; b < DW / 8; b++) m[b*8 +: 8] = {8{wstrb[b]}};
    end

    // hardware set is ORed last so it wins over a same-cycle clear
    always_comb begin
        nxt = MODE == W1C ? ((wr_en ? r & ~(wdata & m) : r) | hw_set)
                          : (wr_en ? (r & ~m) | (wdata & m) : r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r        <= '0;
            wr_pulse <= 1'b0;
        end else begin
            r        <= nxt;
            wr_pulse <= wr_en;
        end
    end

    assign q = MODE == RO ? hw_in : r;
endmodule

// File: rtl/axil_reg_bank.sv
// axil_reg_bank: AXI4-Lite slave with NUM_REGS registers, each RW, RO (hw_in) or W1C (hw_set).
module axil_reg_bank
    import axil_reg_bank_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK   = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    axil_reg_bank_if.slave                 s_axi,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int SW  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(SW);
    localparam int IW  = ADDR_WIDTH - LSB;

    logic                  aw_held, w_held, aw_hs, w_hs, ar_hs, commit, wr_err, rd_err;
    logic [IW-1:0]         aw_idx_q, wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] w_data_q, wr_data, rd_data;
    logic [SW-1:0]         w_strb_q, wr_strb;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  unused;

    assign s_axi.S_AXI_AWREADY = !ARESET && !aw_held && !s_axi.S_AXI_BVALID;
    assign s_axi.S_AXI_WREADY  = !ARESET && !w_held && !s_axi.S_AXI_BVALID;
    assign s_axi.S_AXI_ARREADY = !ARESET && !s_axi.S_AXI_RVALID;

    assign aw_hs  = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_hs   = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
    assign ar_hs  = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    // a half arriving this cycle commits together with the half already held
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_idx  = aw_held ? aw_idx_q : s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
    assign wr_data = w_held ? w_data_q : s_axi.S_AXI_WDATA;
    assign wr_strb = w_held ? w_strb_q : s_axi.S_AXI_WSTRB;
    assign rd_idx  = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:LSB];
    assign unused  = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[LSB-1:0], s_axi.S_AXI_ARADDR[LSB-1:0]};

    // out-of-range indices fall through with the error flags still set
    always_comb begin
        wr_err  = 1'b1;
        rd_err  = 1'b1;
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (32'(wr_idx) == k) wr_err = RO_MASK[k];
            if (32'(rd_idx) == k) begin
                rd_err  = 1'b0;
                rd_data = regs[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        localparam reg_mode_e MODE = RO_MASK[g] ? RO : (W1C_MASK[g] ? W1C : RW);
        axil_reg_cell #(.DW(DATA_WIDTH), .MODE(MODE)) u_cell (
            .clk     (ACLK),
            .rst     (ARESET),
            .wr_en   (commit && !wr_err && 32'(wr_idx) == g),
            .wdata   (wr_data),
            .wstrb   (wr_strb),
            .hw_in   (hw_in[g*DATA_WIDTH +: DATA_WIDTH]),
            .hw_set  (hw_set[g*DATA_WIDTH +: DATA_WIDTH]),
            .q       (regs[g]),
            .wr_pulse(wr_pulse[g])
        );
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held            <= 1'b0;
            w_held             <= 1'b0;
            aw_idx_q           <= '0;
            w_data_q           <= '0;
            w_strb_q           <= '0;
            s_axi.S_AXI_BVALID <= 1'b0;
            s_axi.S_AXI_BRESP  <= RESP_OKAY;
            s_axi.S_AXI_RVALID <= 1'b0;
            s_axi.S_AXI_RDATA  <= '0;
            s_axi.S_AXI_RRESP  <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held            <= 1'b0;
                w_held             <= 1'b0;
                s_axi.S_AXI_BVALID <= 1'b1;
                s_axi.S_AXI_BRESP  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_axi.S_AXI_WDATA;
                    w_strb_q <= s_axi.S_AXI_WSTRB;
                end
                if (s_axi.S_AXI_BVALID && s_axi.S_AXI_BREADY) s_axi.S_AXI_BVALID <= 1'b0;
            end
            if (ar_hs) begin
                s_axi.S_AXI_RVALID <= 1'b1;
                s_axi.S_AXI_RDATA  <= rd_data;
                s_axi.S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi.S_AXI_RVALID && s_axi.S_AXI_RREADY) begin
                s_axi.S_AXI_RVALID <= 1'b0;
            end
        end
    end
endmodule

// File: doc/axil_reg_bank.md
# axil_reg_bank

Parametrised AXI4-Lite slave register bank, the next-generation control/status interface between the processing system and the SAT-solver fabric. It generalises the fixed four-register, write/read-back peripheral to N registers of configurable width. Each register has a mode: read/write, read-only (driven by hardware), or write-1-to-clear (set by hardware). It also adds byte strobes, SLVERR decoding and per-register write strobes toward the core.

## Interface
- DATA_WIDTH, 32: AXI data width; 32 or 64 only.
- ADDR_WIDTH, 8: AXI address width; must satisfy 2^ADDR_WIDTH ≥ NUM_REGS·DATA_WIDTH/8.
- NUM_REGS, 16: number of registers, 1..256.
- RO_MASK, '0 (NUM_REGS bits): bit i=1 makes register i read-only, value taken from hw_in.
- W1C_MASK, '0 (NUM_REGS bits): bit i=1 makes register i write-1-to-clear with hardware set. RO_MASK has priority if both bits are set.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset, synchronous and active-high.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  AXI4-Lite write-address channel; AWPROT is ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  write-data channel; DATA_WIDTH and DATA_WIDTH/8 bits wide.
- S_AXI_BRESP/BVALID/BREADY  write-response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  read-address channel; ARPROT is ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY  read-data channel.
- hw_in  in  NUM_REGS·DATA_WIDTH  read-only register sources; register i is in slice i.
- hw_set  in  NUM_REGS·DATA_WIDTH  per-bit set pulses for W1C registers; ignored for other modes.
- reg_out  out  NUM_REGS·DATA_WIDTH  current contents of every register.
- wr_pulse  out  NUM_REGS  one-cycle strobe when a bus write commits to register i.

## Operation
- Address decode: index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]. Low address bits are ignored.
- Write address (AW) and write data (W) are accepted independently and in any order, each into a one-entry holding buffer.
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - One write is outstanding at a time.
- Commit: happens in the cycle after both AW and W are available. Either may be arriving or already held.
- RW register, commit: each byte lane with WSTRB=1 takes WDATA; other lanes are unchanged.
- W1C register, commit: bits with WDATA=1 in strobed lanes clear. hw_set wins over a clear in the same cycle. hw_set alone ORs into the register every cycle.
- RO register, index ≥ NUM_REGS: no state change; BRESP=SLVERR (2'b10) and wr_pulse stays low.
- All other writes: BRESP=OKAY (2'b00).
- Read: ARREADY = !RVALID.
  - RDATA for an RW or W1C register is the register value before any write committing in the same edge.
  - RDATA for an RO register is hw_in sampled at the AR handshake.
  - Index ≥ NUM_REGS: RDATA=0, RRESP=SLVERR.
- The read and write paths are independent. A read and a write to the same register in the same cycle return the old value.

## Timing
- Reset values: all registers 0; AWREADY, WREADY, ARREADY 0 while ARESET=1; BVALID, RVALID, wr_pulse 0; BRESP, RRESP, RDATA 0.
- After ARESET falls, AWREADY, WREADY and ARREADY are 1 in the next cycle.
- Write latency: last of AW/W handshakes in cycle t → in cycle t+1, reg_out shows the new value, BVALID=1 and wr_pulse[i]=1 for exactly one cycle.
- BVALID holds until BREADY. AWREADY and WREADY stay low meanwhile, so peak throughput is one write per 2 cycles.
- Read latency: AR handshake in cycle t → RVALID=1 in cycle t+1. RDATA and RRESP are stable until RREADY.
- ARESET mid-transaction: held AW/W are discarded, no commit occurs, and outstanding B/R are dropped. All outputs return to their reset values on the next edge.

## Structure
- Package axil_reg_bank_pkg: RESP_OKAY and RESP_SLVERR constants, and the reg_mode_e enum (RW, RO, W1C).
- Sub-module axil_reg_cell: one register with mode, strobe merge, W1C/set logic and wr_pulse. It is instantiated NUM_REGS times by a generate loop.
- Top level holds the AW/W buffers, the B/R handshake state, the address decode and the read mux.

## Test plan
Configuration: NUM_REGS=4, DATA_WIDTH=32, RO_MASK=4'b0100, W1C_MASK=4'b1000.

1. Write 0x1 and 0x2 to addresses 0x0 and 0x4, then read both back → 0x00000001 and 0x00000002, BRESP/RRESP OKAY.
2. Present W three cycles before AW to address 0x4: data 0xA5A5A5A5, WSTRB 4'b0011, over 0x2 → reg 1 becomes 0x0000A5A5. BVALID and wr_pulse[1] rise exactly 1 cycle after the AW handshake.
3. Write to address 0x8 → SLVERR, reg 2 unchanged. Read address 0x8 with hw_in slice 2 = 0xDEADBEEF → 0xDEADBEEF, OKAY. Read address 0x10 → RDATA 0, SLVERR.
4. Pulse hw_set slice 3 = 0xF → read 0xF. Write 0x5 → read 0xA. Write 0x3 with hw_set bit 0 in the commit cycle → read 0x9.
5. Hold BREADY low 5 cycles → BVALID held, AWREADY/WREADY low, a second AW/W pair is not committed. Hold RREADY low → RDATA stable.
6. Assert ARESET after an AW-only handshake → next cycle all reg_out are 0 and BVALID/RVALID are 0. A subsequent lone W does not commit.
